game_seq_ctrl: RTL and testbench

- Main round sequencer for the 5x5 minesweeper core.
- Steps each game through placement, input wait, load, decode, ALU and display phases using level command / done handshakes with the sub-blocks.
- Validates the player's cell index, counts completed rounds and detects hung sub-blocks with a watchdog.
- Sits between the top-level inputs and the placement, decode, ALU and display datapaths.

---
 rtl/game_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the 5x5 minesweeper core: drives the place/load/decode/alu/display phases.
// Optional watchdog and FAULT state are enabled by defining GAME_SEQ_WATCHDOG_EN.
module game_seq_ctrl #(
    parameter int CELLS   = 25,
    parameter int TIMEOUT = 16,
    parameter int RCNT_W  = 5
) (
    input  logic              in_clka,
    input  logic              in_restart,
    input  logic              in_place,
    input  logic              in_data_in,
    input  logic [4:0]        in_data,
    input  logic              in_place_done,
    input  logic              in_decode_done,
    input  logic              in_alu_done,
    input  logic              in_gameover,
    input  logic              in_win,
    input  logic              in_display_done,
    output logic [3:0]        out_state_main,
    output logic              out_start,
    output logic              out_load,
    output logic              out_decode,
    output logic              out_alu,
    output logic              out_display,
    output logic [4:0]        out_temp_data_in,
    output logic              out_bad_input,
    output logic [RCNT_W-1:0] out_round_cnt,
    output logic              out_fault
);

    // Handshake: each command is high for as long as the FSM sits in its phase;
    // the phase ends on the edge where its done input is sampled high.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PLACE   = 4'd1,
        S_WAIT    = 4'd2,
        S_LOAD    = 4'd3,
        S_DECODE  = 4'd4,
        S_ALU     = 4'd5,
        S_DISPLAY = 4'd6,
        S_OVER    = 4'd7,
        S_WIN     = 4'd8,
        S_FAULT   = 4'd9
    } state_t;

    if (TIMEOUT < 2 || CELLS > 32) begin : g_param_check
        $error("game_seq_ctrl: TIMEOUT must be >= 2 and CELLS <= 32");
    end

    state_t            state_q, state_d;
    logic [4:0]        temp_q, temp_d;
    logic              bad_q, bad_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              fault_q, fault_d;
    logic              phase_done;

`ifdef GAME_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            in_phase;
`endif

    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            S_PLACE:   phase_done = in_place_done;
            S_DECODE:  phase_done = in_decode_done;
            S_ALU:     phase_done = in_alu_done;
            S_DISPLAY: phase_done = in_display_done;
            default:   phase_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        bad_d   = 1'b0;
        rcnt_d  = rcnt_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE:  if (in_place) state_d = S_PLACE;
            S_PLACE: if (phase_done) state_d = S_WAIT;
            S_WAIT: begin
                if (in_data_in) begin
                    if (32'(in_data) < CELLS) begin
                        state_d = S_LOAD;
                        temp_d  = in_data;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_LOAD:   state_d = S_DECODE;
            S_DECODE: if (phase_done) state_d = S_ALU;
            S_ALU: begin
                if (phase_done) begin
                    if (in_gameover)  state_d = S_OVER;
                    else if (in_win)  state_d = S_WIN;
                    else              state_d = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (phase_done) begin
                    state_d = S_WAIT;
                    if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_OVER, S_WIN, S_FAULT: begin
                if (in_place) begin
                    state_d = S_PLACE;
                    rcnt_d  = '0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef GAME_SEQ_WATCHDOG_EN
        // A done arriving on the timeout cycle still advances the phase.
        in_phase = (state_q == S_PLACE) || (state_q == S_DECODE) ||
                   (state_q == S_ALU)   || (state_q == S_DISPLAY);
        wd_d = '0;
        if (in_phase && !phase_done) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            state_q <= S_IDLE;
            temp_q  <= '0;
            bad_q   <= 1'b0;
            rcnt_q  <= '0;
            fault_q <= 1'b0;
`ifdef GAME_SEQ_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            bad_q   <= bad_d;
            rcnt_q  <= rcnt_d;
            fault_q <= fault_d;
`ifdef GAME_SEQ_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign out_state_main   = state_q;
    assign out_start        = (state_q == S_PLACE);
    assign out_load         = (state_q == S_LOAD);
    assign out_decode       = (state_q == S_DECODE);
    assign out_alu          = (state_q == S_ALU);
    assign out_display      = (state_q == S_DISPLAY);
    assign out_temp_data_in = temp_q;
    assign out_bad_input    = bad_q;
    assign out_round_cnt    = rcnt_q;
    assign out_fault        = fault_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_game_seq_ctrl;

    localparam int CELLS   = 25;
    localparam int TIMEOUT = 16;
    localparam int RCNT_W  = 5;
`ifdef GAME_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              in_clka = 1'b0;
    logic              in_restart;
    logic              in_place, in_data_in;
    logic [4:0]        in_data;
    logic              in_place_done, in_decode_done, in_alu_done;
    logic              in_gameover, in_win, in_display_done;
    logic [3:0]        out_state_main;
    logic              out_start, out_load, out_decode, out_alu, out_display;
    logic [4:0]        out_temp_data_in;
    logic              out_bad_input;
    logic [RCNT_W-1:0] out_round_cnt;
    logic              out_fault;
    logic [20:0]       obs;

    always #5 in_clka = ~in_clka;

    game_seq_ctrl #(.CELLS(CELLS), .TIMEOUT(TIMEOUT), .RCNT_W(RCNT_W)) dut (
        .in_clka(in_clka), .in_restart(in_restart), .in_place(in_place),
        .in_data_in(in_data_in), .in_data(in_data), .in_place_done(in_place_done),
        .in_decode_done(in_decode_done), .in_alu_done(in_alu_done),
        .in_gameover(in_gameover), .in_win(in_win), .in_display_done(in_display_done),
        .out_state_main(out_state_main), .out_start(out_start), .out_load(out_load),
        .out_decode(out_decode), .out_alu(out_alu), .out_display(out_display),
        .out_temp_data_in(out_temp_data_in), .out_bad_input(out_bad_input),
        .out_round_cnt(out_round_cnt), .out_fault(out_fault)
    );

    assign obs = {out_state_main, out_start, out_load, out_decode, out_alu, out_display,
                  out_temp_data_in, out_bad_input, out_round_cnt, out_fault};

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: phase number, cycles spent in the current phase, and visible results.
    int m_state, m_temp, m_rcnt, m_age;
    bit m_bad, m_fault;

    function automatic void model_reset();
        m_state = 0; m_temp = 0; m_rcnt = 0; m_age = 0; m_bad = 0; m_fault = 0;
    endfunction

    function automatic void model_step();
        int  nxt;
        bit  waiting_on_done;
        nxt = m_state;
        m_bad = 0;
        waiting_on_done = 0;
        case (m_state)
            0: if (in_place) nxt = 1;
            1: begin waiting_on_done = !in_place_done; if (in_place_done) nxt = 2; end
            2: if (in_data_in) begin
                   if (int'(in_data) < CELLS) begin nxt = 3; m_temp = int'(in_data); end
                   else m_bad = 1;
               end
            3: nxt = 4;
            4: begin waiting_on_done = !in_decode_done; if (in_decode_done) nxt = 5; end
            5: begin
                   waiting_on_done = !in_alu_done;
                   if (in_alu_done) nxt = in_gameover ? 7 : (in_win ? 8 : 6);
               end
            6: begin
                   waiting_on_done = !in_display_done;
                   if (in_display_done) begin
                       nxt = 2;
                       m_rcnt = (m_rcnt + 1 > 31) ? 31 : m_rcnt + 1;
                   end
               end
            default: if (in_place) begin nxt = 1; m_rcnt = 0; m_fault = 0; end
        endcase
        if (WD && waiting_on_done && m_age == TIMEOUT - 1) begin
            nxt = 9;
            m_fault = 1;
        end
        m_age = (nxt == m_state) ? m_age + 1 : 0;
        m_state = nxt;
    endfunction

    function automatic logic [20:0] exp_bundle();
        logic [3:0] s;
        s = 4'(m_state);
        return {s, m_state == 1, m_state == 3, m_state == 4, m_state == 5, m_state == 6,
                5'(m_temp), m_bad, 5'(m_rcnt), m_fault};
    endfunction

    task automatic clear_inputs();
        in_place = 0; in_data_in = 0; in_data = 0; in_place_done = 0; in_decode_done = 0;
        in_alu_done = 0; in_gameover = 0; in_win = 0; in_display_done = 0;
    endtask

    task automatic tick();
        @(posedge in_clka);
        model_step();
        #1;
    endtask

    // which: 0 place, 1 decode, 2 alu, 3 display
    task automatic drive_phase(input int which, input int delay);
        repeat (delay) tick();
        case (which)
            0: in_place_done = 1;
            1: in_decode_done = 1;
            2: in_alu_done = 1;
            default: in_display_done = 1;
        endcase
        tick();
        in_place_done = 0; in_decode_done = 0; in_alu_done = 0; in_display_done = 0;
    endtask

    task automatic enter_decode();
        in_data_in = 1;
        in_data = 5'($urandom_range(0, CELLS - 1));
        tick();
        in_data_in = 0;
        tick();
    endtask

    task automatic test_reset();
        in_restart = 1;
        clear_inputs();
        model_reset();
        #2;
        n_cmp++;
        if (obs !== 21'd0) begin n_err++; $display("FAIL reset_async: got %h want 0", obs); end
        @(posedge in_clka); #1;
        n_cmp++;
        if (obs !== 21'd0) begin n_err++; $display("FAIL reset_held: got %h want 0", obs); end
        in_restart = 0;
    endtask

    task automatic test_place();
        in_place = 1; tick(); in_place = 0;
        n_cmp++;
        if ({out_state_main, out_start} !== {4'd1, 1'b1}) begin
            n_err++; $display("FAIL place_enter: got state %0d start %0b want 1 1", out_state_main, out_start);
        end
        drive_phase(0, 0);
        n_cmp++;
        if ({out_state_main, out_start} !== {4'd2, 1'b0}) begin
            n_err++; $display("FAIL place_done: got state %0d start %0b want 2 0", out_state_main, out_start);
        end
    endtask

    task automatic test_valid_input();
        in_data_in = 1; in_data = 5'd2; tick(); in_data_in = 0;
        n_cmp++;
        if ({out_state_main, out_load, out_temp_data_in} !== {4'd3, 1'b1, 5'd2}) begin
            n_err++; $display("FAIL load_enter: got state %0d load %0b temp %0d want 3 1 2",
                              out_state_main, out_load, out_temp_data_in);
        end
        tick();
        n_cmp++;
        if ({out_state_main, out_load, out_decode} !== {4'd4, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL load_one_cycle: got state %0d load %0b decode %0b want 4 0 1",
                              out_state_main, out_load, out_decode);
        end
    endtask

    task automatic test_rounds();
        drive_phase(1, 2);
        n_cmp++;
        if ({out_state_main, out_alu} !== {4'd5, 1'b1}) begin
            n_err++; $display("FAIL round1_alu: got state %0d alu %0b want 5 1", out_state_main, out_alu);
        end
        drive_phase(2, 2);
        drive_phase(3, 2);
        n_cmp++;
        if ({out_state_main, out_round_cnt} !== {4'd2, 5'd1}) begin
            n_err++; $display("FAIL round1_done: got state %0d rcnt %0d want 2 1", out_state_main, out_round_cnt);
        end
        in_data_in = 1; in_data = 5'd5; tick(); in_data_in = 0;
        tick();
        drive_phase(1, 0); drive_phase(2, 0); drive_phase(3, 0);
        n_cmp++;
        if ({out_state_main, out_round_cnt, out_temp_data_in} !== {4'd2, 5'd2, 5'd5}) begin
            n_err++; $display("FAIL round2_done: got state %0d rcnt %0d temp %0d want 2 2 5",
                              out_state_main, out_round_cnt, out_temp_data_in);
        end
    endtask

    task automatic test_bad_input();
        in_data_in = 1; in_data = 5'd25; tick(); in_data_in = 0;
        n_cmp++;
        if ({out_state_main, out_bad_input, out_temp_data_in} !== {4'd2, 1'b1, 5'd5}) begin
            n_err++; $display("FAIL bad_pulse: got state %0d bad %0b temp %0d want 2 1 5",
                              out_state_main, out_bad_input, out_temp_data_in);
        end
        tick();
        n_cmp++;
        if ({out_state_main, out_bad_input} !== {4'd2, 1'b0}) begin
            n_err++; $display("FAIL bad_one_cycle: got state %0d bad %0b want 2 0", out_state_main, out_bad_input);
        end
        in_data_in = 1; in_data = 5'd24; tick(); in_data_in = 0;
        n_cmp++;
        if ({out_state_main, out_temp_data_in} !== {4'd3, 5'd24}) begin
            n_err++; $display("FAIL max_index: got state %0d temp %0d want 3 24", out_state_main, out_temp_data_in);
        end
        tick();
        drive_phase(1, 0);
    endtask

    task automatic test_gameover();
        in_gameover = 1; in_win = 1;
        drive_phase(2, 0);
        in_gameover = 0; in_win = 0;
        n_cmp++;
        if ({out_state_main, out_round_cnt} !== {4'd7, 5'd2}) begin
            n_err++; $display("FAIL gameover_prio: got state %0d rcnt %0d want 7 2", out_state_main, out_round_cnt);
        end
        in_place = 1; tick(); in_place = 0;
        n_cmp++;
        if ({out_state_main, out_round_cnt, out_start} !== {4'd1, 5'd0, 1'b1}) begin
            n_err++; $display("FAIL restart_game: got state %0d rcnt %0d start %0b want 1 0 1",
                              out_state_main, out_round_cnt, out_start);
        end
    endtask

    task automatic test_saturation();
        drive_phase(0, 0);
        for (int r = 1; r <= 33; r++) begin
            in_data_in = 1; in_data = 5'(r % CELLS); tick(); in_data_in = 0;
            tick();
            drive_phase(1, 0); drive_phase(2, 0); drive_phase(3, 0);
            if (r == 31) begin
                n_cmp++;
                if (out_round_cnt !== 5'd31) begin
                    n_err++; $display("FAIL rcnt_31: got %0d want 31", out_round_cnt);
                end
            end
        end
        n_cmp++;
        if (out_round_cnt !== 5'd31) begin n_err++; $display("FAIL rcnt_saturate: got %0d want 31", out_round_cnt); end
        in_place = 1; tick(); in_place = 0;
        n_cmp++;
        if (out_state_main !== 4'd2) begin n_err++; $display("FAIL place_ignored: got state %0d want 2", out_state_main); end
    endtask

    task automatic test_watchdog();
        logic [3:0] exp_s;
        enter_decode();
        repeat (15) tick();
        n_cmp++;
        if (out_state_main !== 4'd4) begin n_err++; $display("FAIL wd_15: got state %0d want 4", out_state_main); end
        tick();
        exp_s = WD ? 4'd9 : 4'd4;
        n_cmp++;
        if ({out_state_main, out_fault} !== {exp_s, WD}) begin
            n_err++; $display("FAIL wd_16: got state %0d fault %0b want %0d %0b", out_state_main, out_fault, exp_s, WD);
        end
`ifdef GAME_SEQ_WATCHDOG_EN
        in_place = 1; tick(); in_place = 0;
        n_cmp++;
        if ({out_state_main, out_fault} !== {4'd1, 1'b0}) begin
            n_err++; $display("FAIL fault_clear: got state %0d fault %0b want 1 0", out_state_main, out_fault);
        end
        drive_phase(0, 0);
`else
        drive_phase(1, 0); drive_phase(2, 0); drive_phase(3, 0);
`endif
        enter_decode();
        repeat (15) tick();
        drive_phase(1, 0);
        n_cmp++;
        if ({out_state_main, out_fault} !== {4'd5, 1'b0}) begin
            n_err++; $display("FAIL wd_done_wins: got state %0d fault %0b want 5 0", out_state_main, out_fault);
        end
    endtask

    task automatic test_async_abort();
        in_restart = 1;
        #1;
        n_cmp++;
        if (obs !== 21'd0) begin n_err++; $display("FAIL async_abort: got %h want 0", obs); end
        model_reset();
        #3;
        in_restart = 0;
    endtask

    task automatic test_random();
        int done_pct;
        done_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) done_pct = ($urandom_range(0, 1) == 0) ? 50 : 4;
            in_place        = ($urandom_range(0, 7) == 0);
            in_data_in      = ($urandom_range(0, 2) == 0);
            in_data         = 5'($urandom_range(0, 31));
            in_place_done   = ($urandom_range(0, 99) < done_pct);
            in_decode_done  = ($urandom_range(0, 99) < done_pct);
            in_alu_done     = ($urandom_range(0, 99) < done_pct);
            in_display_done = ($urandom_range(0, 99) < done_pct);
            in_gameover     = ($urandom_range(0, 5) == 0);
            in_win          = ($urandom_range(0, 5) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_bundle()) begin
                n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp_bundle());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_place();
        test_valid_input();
        test_rounds();
        test_bad_input();
        test_gameover();
        test_saturation();
        test_watchdog();
        test_async_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
